// File: rtl/mips_pkg.sv
// Shared widths, types and the ID/EX payload struct for the decode/execute boundary.
package mips_pkg;

   localparam int DATA_W         = 32;
   localparam int ADDR_W         = 5;
   localparam int CTRL_W         = 8;
   localparam int CTRL_MEMRD_BIT = 0;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef struct packed {
      reg_addr_t           rs_addr;
      reg_addr_t           rt_addr;
      reg_addr_t           rd_addr;
      word_t               rs_val;
      word_t               rt_val;
      word_t               imm;
      logic [CTRL_W-1:0]   ctrl;
   } id_ex_t;

endpackage

// File: rtl/operand_bypass.sv
// Picks one operand from register data or the in-flight writeback by address match.
// With ID_EX_ZERO_REG_EN defined, address 0 never matches and always reads as zero.
module operand_bypass
   import mips_pkg::*;
(
   input  reg_addr_t addr,
   input  word_t     reg_data,
   input  logic      wb_we,
   input  reg_addr_t wb_addr,
   input  word_t     wb_data,
   output word_t     val
);

`ifdef ID_EX_ZERO_REG_EN
   always_comb begin
      val = reg_data;
      if (addr == '0)
         val = '0;
      else if (wb_we && (wb_addr == addr))
         val = wb_data;
   end
`else
   always_comb begin
      val = reg_data;
      if (wb_we && (wb_addr == addr))
         val = wb_data;
   end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use stall, back-pressure and flush.
// Optional macro ID_EX_ZERO_REG_EN makes register 0 hard-wired to zero.
module id_ex_stage
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   output logic              id_ready,
   input  reg_addr_t         id_rs_addr,
   input  reg_addr_t         id_rt_addr,
   input  reg_addr_t         id_rd_addr,
   input  word_t             id_rs_data,
   input  word_t             id_rt_data,
   input  word_t             id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_we,
   input  reg_addr_t         wb_addr,
   input  word_t             wb_data,
   input  logic              flush,
   output logic              ex_valid,
   input  logic              ex_ready,
   output word_t             ex_rs_val,
   output word_t             ex_rt_val,
   output reg_addr_t         ex_rs_addr,
   output reg_addr_t         ex_rt_addr,
   output reg_addr_t         ex_rd_addr,
   output word_t             ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl
);

   id_ex_t ex_q;
   logic   valid_q;
   word_t  cap_rs, cap_rt, hold_rs, hold_rt;
   logic   rd_match, hazard, accept, leave;

   operand_bypass u_cap_rs (.addr(id_rs_addr), .reg_data(id_rs_data), .wb_we(wb_we),
                            .wb_addr(wb_addr), .wb_data(wb_data), .val(cap_rs));
   operand_bypass u_cap_rt (.addr(id_rt_addr), .reg_data(id_rt_data), .wb_we(wb_we),
                            .wb_addr(wb_addr), .wb_data(wb_data), .val(cap_rt));
   operand_bypass u_hold_rs (.addr(ex_q.rs_addr), .reg_data(ex_q.rs_val), .wb_we(wb_we),
                             .wb_addr(wb_addr), .wb_data(wb_data), .val(hold_rs));
   operand_bypass u_hold_rt (.addr(ex_q.rt_addr), .reg_data(ex_q.rt_val), .wb_we(wb_we),
                             .wb_addr(wb_addr), .wb_data(wb_data), .val(hold_rt));

   always_comb begin
      rd_match = (ex_q.rd_addr == id_rs_addr) || (ex_q.rd_addr == id_rt_addr);
`ifdef ID_EX_ZERO_REG_EN
      if (ex_q.rd_addr == '0)
         rd_match = 1'b0;
`endif
      hazard   = valid_q && ex_q.ctrl[CTRL_MEMRD_BIT] && id_valid && rd_match;
      id_ready = !rst && !flush && !hazard && (!valid_q || ex_ready);
      accept   = id_valid && id_ready;
      leave    = valid_q && ex_ready;
   end

   // Priority: reset, flush, new capture, drain to bubble, refresh of a stalled entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ex_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q      <= 1'b1;
         ex_q.rs_addr <= id_rs_addr;
         ex_q.rt_addr <= id_rt_addr;
         ex_q.rd_addr <= id_rd_addr;
         ex_q.rs_val  <= cap_rs;
         ex_q.rt_val  <= cap_rt;
         ex_q.imm     <= id_imm;
         ex_q.ctrl    <= id_ctrl;
      end else if (leave) begin
         valid_q <= 1'b0;
      end else if (valid_q) begin
         ex_q.rs_val <= hold_rs;
         ex_q.rt_val <= hold_rt;
      end
   end

   always_comb begin
      ex_valid   = valid_q;
      ex_rs_val  = ex_q.rs_val;
      ex_rt_val  = ex_q.rt_val;
      ex_rs_addr = ex_q.rs_addr;
      ex_rt_addr = ex_q.rt_addr;
      ex_rd_addr = ex_q.rd_addr;
      ex_imm     = ex_q.imm;
      ex_ctrl    = ex_q.ctrl;
   end

endmodule
